// File: rtl/cbm2_cycle_sched_if.sv
// Bus bundle for the CBM-II cycle scheduler: loader/video/CPU/RAM handshake
// inputs and the slot ownership, strobe and clock-enable outputs.
interface cbm2_cycle_sched_if;
    logic model;
    logic vid_en;
    logic ld_req;
    logic ld_hold;
    logic ram_ack;
    logic phase;
    logic cpuCycle;
    logic vidCycle;
    logic ldCycle;
    logic ram_req;
    logic ld_ack;
    logic cpu_ce;
    logic vid_ce;
    logic stretched;

    modport master (
        output model, vid_en, ld_req, ld_hold, ram_ack,
        input  phase, cpuCycle, vidCycle, ldCycle, ram_req, ld_ack,
               cpu_ce, vid_ce, stretched
    );

    modport slave (
        input  model, vid_en, ld_req, ld_hold, ram_ack,
        output phase, cpuCycle, vidCycle, ldCycle, ram_req, ld_ack,
               cpu_ce, vid_ce, stretched
    );
endinterface

// File: rtl/cbm2_cycle_sched.sv
// CBM-II bus-cycle scheduler: alternating video/CPU half-cycles of HALF clocks,
// one RAM request per slot, slot stretching on late acks, loader slot stealing.
module cbm2_cycle_sched #(
    parameter int unsigned HALF = 16
) (
    input  logic               clk_sys,
    input  logic               reset,
    cbm2_cycle_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, NONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_LD} owner_t;

    localparam logic [7:0] LAST = 8'(HALF - 1);

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     sel_owner, act_owner;
    logic [7:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;
    logic       cpu_ce_q, cpu_ce_d;
    logic       vid_ce_q, vid_ce_d;
    logic       stretched_q, stretched_d;
    logic       model_q, model_d;
    logic       slot_start, issue, waiting, hold, wrap;
    logic       model_unused;

    // The chip-select decoding for VIC/CRTC lives downstream; the slot-start
    // latch only guarantees a mid-slot change takes effect next slot.
    assign model_unused = model_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            cnt_q       <= 8'd0;
            phase_q     <= 1'b0;
            cpu_ce_q    <= 1'b0;
            vid_ce_q    <= 1'b0;
            stretched_q <= 1'b0;
            model_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            cpu_ce_q    <= cpu_ce_d;
            vid_ce_q    <= vid_ce_d;
            stretched_q <= stretched_d;
            model_q     <= model_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        model_d     = model_q;
        slot_start  = (state_q == IDLE) && (cnt_q == 8'd1);

        if (phase_q)
            sel_owner = OWN_CPU;
        else if (bus.vid_en)
            sel_owner = OWN_VID;
        else if (bus.ld_req)
            sel_owner = OWN_LD;
        else
            sel_owner = OWN_NONE;

        issue   = slot_start && (sel_owner != OWN_NONE);
        waiting = issue || (state_q == WAIT);

        if (issue)
            act_owner = sel_owner;
        else if (state_q == WAIT)
            act_owner = owner_q;
        else
            act_owner = OWN_NONE;

        // A request still outstanding at the last count freezes the counter.
        hold = (cnt_q == LAST) && (state_q == WAIT) && !bus.ram_ack;
        wrap = (cnt_q == LAST) && !hold;

        case (state_q)
            IDLE: begin
                if (slot_start) begin
                    model_d = bus.model;
                    if (issue) begin
                        owner_d = sel_owner;
                        state_d = bus.ram_ack ? DONE : WAIT;
                    end else begin
                        state_d = NONE;
                    end
                end
            end
            WAIT:    if (bus.ram_ack) state_d = DONE;
            DONE:    state_d = DONE;
            NONE:    state_d = NONE;
            default: state_d = IDLE;
        endcase

        if (wrap)
            state_d = IDLE;

        if (hold)
            cnt_d = cnt_q;
        else if (wrap)
            cnt_d = 8'd0;
        else
            cnt_d = cnt_q + 8'd1;

        phase_d     = wrap ? ~phase_q : phase_q;
        cpu_ce_d    = wrap && phase_q && !bus.ld_hold;
        vid_ce_d    = wrap && !phase_q;
        stretched_d = hold;
    end

    assign bus.phase     = phase_q;
    assign bus.ram_req   = issue;
    assign bus.cpuCycle  = (act_owner == OWN_CPU);
    assign bus.vidCycle  = (act_owner == OWN_VID);
    assign bus.ldCycle   = (act_owner == OWN_LD);
    assign bus.ld_ack    = waiting && bus.ram_ack && (act_owner == OWN_LD);
    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.vid_ce    = vid_ce_q;
    assign bus.stretched = stretched_q;
endmodule

// File: tb/tb_cbm2_cycle_sched.sv
// Randomised and directed bench for cbm2_cycle_sched against a slot-level
// reference model (position within slot, outstanding request, pending enables).
module tb_cbm2_cycle_sched;
    localparam int HALF = 8;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    cbm2_cycle_sched_if bus_if ();

    cbm2_cycle_sched #(.HALF(HALF)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // requested input levels, applied just after each rising edge
    bit drv_reset = 1, drv_vid_en = 1, drv_ld_req = 0, drv_ld_hold = 0, drv_model = 0;
    bit force_ack = 0, rand_mode = 0;
    int dly_cpu = 2, dly_vid = 2, ack_cnt = 0, spurious_pct = 0, k = 0;

    // reference model state
    bit m_valid = 0, m_pend = 0, m_cpu_ce = 0, m_vid_ce = 0;
    int m_pos = 0, m_ph = 0, m_who = 0;

    // observation counters for directed checks
    int n_req, n_cpu_ce, n_vid_ce, n_vidc, n_cpuc, n_ldc, n_ldack, n_str, n_ph1, n_ce_after_ack;
    bit prev_cpu_ack = 0, saw_ld_ack = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, k);
        end
    endtask

    task automatic clr();
        n_req = 0; n_cpu_ce = 0; n_vid_ce = 0; n_vidc = 0; n_cpuc = 0;
        n_ldc = 0; n_ldack = 0; n_str = 0; n_ph1 = 0; n_ce_after_ack = 0;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus_if.phase, bus_if.cpuCycle, bus_if.vidCycle, bus_if.ldCycle,
                    bus_if.ram_req, bus_if.ld_ack, bus_if.cpu_ce, bus_if.vid_ce,
                    bus_if.stretched});
    endfunction

    task automatic sample_and_model();
        int sel, cur;
        bit done;
        sel = (m_ph == 1) ? 1 : (bus_if.vid_en ? 2 : (bus_if.ld_req ? 3 : 0));
        cur = (m_pos == 1) ? sel : (m_pend ? m_who : 0);
        if (m_valid) begin
            check("phase",     32'(bus_if.phase),     32'(m_ph));
            check("ram_req",   32'(bus_if.ram_req),   32'((m_pos == 1) && (sel != 0)));
            check("cpuCycle",  32'(bus_if.cpuCycle),  32'(cur == 1));
            check("vidCycle",  32'(bus_if.vidCycle),  32'(cur == 2));
            check("ldCycle",   32'(bus_if.ldCycle),   32'(cur == 3));
            check("ld_ack",    32'(bus_if.ld_ack),    32'(bus_if.ram_ack && (cur == 3)));
            check("cpu_ce",    32'(bus_if.cpu_ce),    32'(m_cpu_ce));
            check("vid_ce",    32'(bus_if.vid_ce),    32'(m_vid_ce));
            check("stretched", 32'(bus_if.stretched), 32'(m_pos >= HALF));
            if (bus_if.ram_ack && cur != 0)
                $display("[TB] xfer cycle=%0d owner=%0d phase=%0d pos=%0d", k, cur, m_ph, m_pos);
        end
        n_req    += int'(bus_if.ram_req);
        n_cpu_ce += int'(bus_if.cpu_ce);
        n_vid_ce += int'(bus_if.vid_ce);
        n_vidc   += int'(bus_if.vidCycle);
        n_cpuc   += int'(bus_if.cpuCycle);
        n_ldc    += int'(bus_if.ldCycle);
        n_ldack  += int'(bus_if.ld_ack);
        n_str    += int'(bus_if.stretched);
        n_ph1    += int'(bus_if.phase);
        if (bus_if.cpu_ce && prev_cpu_ack) n_ce_after_ack++;
        prev_cpu_ack = bus_if.ram_ack && bus_if.cpuCycle;
        if (bus_if.ld_ack) saw_ld_ack = 1;

        // advance the model to the upcoming edge
        if (reset) begin
            m_pos = 0; m_ph = 0; m_pend = 0; m_who = 0;
            m_cpu_ce = 0; m_vid_ce = 0; m_valid = 1;
        end else begin
            if (m_pos == 1) begin
                m_who  = sel;
                m_pend = (sel != 0) && !bus_if.ram_ack;
            end else if (m_pend && bus_if.ram_ack) begin
                m_pend = 0;
            end
            done     = (m_pos >= HALF - 1) && !m_pend;
            m_cpu_ce = done && (m_ph == 1) && !bus_if.ld_hold;
            m_vid_ce = done && (m_ph == 0);
            m_pos    = done ? 0 : m_pos + 1;
            if (done) m_ph ^= 1;
        end
    endtask

    task automatic cycle();
        int d;
        @(posedge clk_sys);
        #1;
        if (rand_mode) begin
            drv_vid_en  = ($urandom_range(0, 3) != 0);
            drv_ld_hold = ($urandom_range(0, 4) == 0);
            drv_model   = $urandom_range(0, 1) == 1;
            if (saw_ld_ack) drv_ld_req = 0;
            else if (!drv_ld_req && $urandom_range(0, 2) == 0) drv_ld_req = 1;
            drv_reset = ($urandom_range(0, 299) == 0);
        end
        saw_ld_ack     = 0;
        reset          = drv_reset;
        bus_if.vid_en  = drv_vid_en;
        bus_if.ld_req  = drv_ld_req;
        bus_if.ld_hold = drv_ld_hold;
        bus_if.model   = drv_model;
        bus_if.ram_ack = 1'b0;
        if (reset) begin
            ack_cnt = 0;
        end else if (force_ack) begin
            bus_if.ram_ack = 1'b1;
            force_ack = 0;
        end else if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) bus_if.ram_ack = 1'b1;
        end else if (spurious_pct > 0 && $urandom_range(0, 99) < spurious_pct) begin
            bus_if.ram_ack = 1'b1;
        end
        #1;
        if (bus_if.ram_req) begin
            d = bus_if.cpuCycle ? dly_cpu : dly_vid;
            if (rand_mode) d = $urandom_range(0, 12);
            if (d == 0) bus_if.ram_ack = 1'b1;
            else ack_cnt = d;
        end
        @(negedge clk_sys);
        sample_and_model();
        k++;
    endtask

    initial begin
        int waited, first_req, first_ph;
        bus_if.vid_en = 1'b1; bus_if.ld_req = 1'b0; bus_if.ld_hold = 1'b0;
        bus_if.model = 1'b0; bus_if.ram_ack = 1'b0;

        // reset state
        drv_reset = 1;
        repeat (4) cycle();
        check("reset_outs", all_outs(), 32'd0);

        // nominal slots, ack two cycles after request
        drv_reset = 0; clr();
        repeat (64) cycle();
        check("A_req",    32'(n_req),    32'd8);
        check("A_vid_ce", 32'(n_vid_ce), 32'd4);
        check("A_cpu_ce", 32'(n_cpu_ce), 32'd3);
        check("A_vidc",   32'(n_vidc),   32'd12);
        check("A_cpuc",   32'(n_cpuc),   32'd12);
        check("A_ph1",    32'(n_ph1),    32'd32);
        check("A_str",    32'(n_str),    32'd0);

        // same-cycle acknowledge
        dly_cpu = 0; dly_vid = 0; clr();
        repeat (32) cycle();
        check("B_req",   32'(n_req),           32'd4);
        check("B_flags", 32'(n_vidc + n_cpuc), 32'd4);
        check("B_str",   32'(n_str),           32'd0);

        // late CPU acknowledge stretches phase 1 to 12 clocks
        dly_cpu = 10; dly_vid = 2; clr();
        repeat (40) cycle();
        check("C_str",        32'(n_str),          32'd8);
        check("C_ph1",        32'(n_ph1),          32'd24);
        check("C_ce_aft_ack", 32'(n_ce_after_ack), 32'd1);
        check("C_req",        32'(n_req),          32'd4);

        // loader takes idle video slots
        dly_cpu = 2; drv_vid_en = 0; drv_ld_req = 1; clr();
        repeat (32) cycle();
        check("D_ldc",    32'(n_ldc),    32'd6);
        check("D_ldack",  32'(n_ldack),  32'd2);
        check("D_vidc",   32'(n_vidc),   32'd0);
        check("D_vid_ce", 32'(n_vid_ce), 32'd2);
        check("D_req",    32'(n_req),    32'd4);

        // CPU frozen for three frames
        drv_vid_en = 1; drv_ld_req = 0; drv_ld_hold = 1;
        cycle(); clr();
        repeat (48) cycle();
        check("E_cpu_ce", 32'(n_cpu_ce), 32'd0);
        check("E_cpuc",   32'(n_cpuc),   32'd9);
        check("E_req",    32'(n_req),    32'd6);
        drv_ld_hold = 0;

        // reset in the middle of a waiting video slot, stale ack afterwards
        dly_vid = 10; waited = 0;
        while (!(bus_if.vidCycle && !bus_if.ram_req) && waited < 40) begin
            cycle();
            waited++;
        end
        check("G_reach_wait", 32'(waited < 40), 32'd1);
        drv_reset = 1;
        repeat (2) cycle();
        check("G_rst_outs1", all_outs(), 32'd0);
        cycle();
        check("G_rst_outs2", all_outs(), 32'd0);
        drv_reset = 0; force_ack = 1; dly_vid = 2; clr();
        first_req = -1; first_ph = -1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (bus_if.ram_req && first_req < 0) begin
                first_req = i;
                first_ph  = int'(bus_if.phase);
            end
        end
        check("G_ldack",     32'(n_ldack),   32'd0);
        check("G_cpu_ce",    32'(n_cpu_ce),  32'd0);
        check("G_first_req", 32'(first_req), 32'd1);
        check("G_first_ph",  32'(first_ph),  32'd0);

        // randomised traffic against the model
        rand_mode = 1; spurious_pct = 3;
        repeat (1500) cycle();
        rand_mode = 0; drv_reset = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
